// File: rtl/core_biu_arbiter_pkg.sv
// Shared encodings and default widths for the BIU memory-port arbiter.
package core_biu_arbiter_pkg;

  localparam int CORE_XLEN            = 32;
  localparam int CORE_LSU_WMASK_WIDTH = 4;

  typedef enum logic [1:0] {
    CORE_BIU_ARB_IDLE = 2'd0,
    CORE_BIU_ARB_REQ  = 2'd1,
    CORE_BIU_ARB_RSP  = 2'd2
  } biu_arb_state_e;

  typedef enum logic {
    CORE_BIU_OWN_IFU = 1'b0,
    CORE_BIU_OWN_LSU = 1'b1
  } biu_own_e;

endpackage

// File: rtl/core_biu_arb_grant.sv
// Two-way combinational grant: fixed LSU priority, or a round-robin tie-break
// when CORE_BIU_ARB_RR_EN is defined.
module core_biu_arb_grant (
  input  logic ifu_valid,
  input  logic lsu_valid,
`ifdef CORE_BIU_ARB_RR_EN
  input  logic rr_favor_ifu,
`endif
  output logic gnt_ifu,
  output logic gnt_lsu
);

`ifdef CORE_BIU_ARB_RR_EN
  assign gnt_lsu = lsu_valid & ~(ifu_valid & rr_favor_ifu);
`else
  assign gnt_lsu = lsu_valid;
`endif
  assign gnt_ifu = ifu_valid & ~gnt_lsu;

endmodule

// File: rtl/core_biu_arbiter.sv
// Shares the single memory port between fetch and load/store, one transaction
// in flight at a time. Define CORE_BIU_ARB_RR_EN for round-robin arbitration.
module core_biu_arbiter
  import core_biu_arbiter_pkg::*;
#(
  parameter int XLEN    = CORE_XLEN,
  parameter int WMASK_W = CORE_LSU_WMASK_WIDTH
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               ifu_req_valid,
  output logic               ifu_req_ready,
  input  logic [XLEN-1:0]    ifu_req_addr,
  input  logic               ifu_flush,
  output logic               ifu_rsp_valid,
  output logic [XLEN-1:0]    ifu_rsp_rdata,

  input  logic               lsu_req_valid,
  output logic               lsu_req_ready,
  input  logic [XLEN-1:0]    lsu_req_addr,
  input  logic [XLEN-1:0]    lsu_req_wdata,
  input  logic [WMASK_W-1:0] lsu_req_wmask,
  input  logic               lsu_req_wen,
  output logic               lsu_rsp_valid,
  output logic [XLEN-1:0]    lsu_rsp_rdata,

  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [XLEN-1:0]    mem_addr,
  output logic [XLEN-1:0]    mem_wdata,
  output logic [WMASK_W-1:0] mem_wmask,
  output logic               mem_wen,
  input  logic               mem_rsp_valid,
  input  logic [XLEN-1:0]    mem_rsp_rdata
);

  biu_arb_state_e state;
  biu_own_e       own;
  logic           drop;
  logic           gnt_ifu;
  logic           gnt_lsu;
  logic           ifu_hs;
  logic           lsu_hs;
  logic           ifu_flush_hit;

  // A fetch being flushed must not win arbitration in that cycle.
  core_biu_arb_grant u_grant (
    .ifu_valid    (ifu_req_valid & ~ifu_flush),
    .lsu_valid    (lsu_req_valid),
`ifdef CORE_BIU_ARB_RR_EN
    .rr_favor_ifu (rr_favor_ifu),
`endif
    .gnt_ifu      (gnt_ifu),
    .gnt_lsu      (gnt_lsu)
  );

  assign ifu_req_ready = (state == CORE_BIU_ARB_IDLE) & gnt_ifu;
  assign lsu_req_ready = (state == CORE_BIU_ARB_IDLE) & gnt_lsu;
  assign ifu_hs        = ifu_req_valid & ifu_req_ready;
  assign lsu_hs        = lsu_req_valid & lsu_req_ready;
  assign mem_req_valid = (state == CORE_BIU_ARB_REQ);
  assign ifu_flush_hit = ifu_flush & (own == CORE_BIU_OWN_IFU);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= CORE_BIU_ARB_IDLE;
      own           <= CORE_BIU_OWN_IFU;
      drop          <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
      mem_wen       <= 1'b0;
      ifu_rsp_valid <= 1'b0;
      ifu_rsp_rdata <= '0;
      lsu_rsp_valid <= 1'b0;
      lsu_rsp_rdata <= '0;
    end else begin
      ifu_rsp_valid <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      case (state)
        CORE_BIU_ARB_IDLE: begin
          if (lsu_hs) begin
            mem_addr  <= lsu_req_addr;
            mem_wdata <= lsu_req_wdata;
            mem_wmask <= lsu_req_wmask;
            mem_wen   <= lsu_req_wen;
            own       <= CORE_BIU_OWN_LSU;
            state     <= CORE_BIU_ARB_REQ;
          end else if (ifu_hs) begin
            // Fetches are reads: never let stale store controls leak through.
            mem_addr  <= ifu_req_addr;
            mem_wdata <= '0;
            mem_wmask <= '0;
            mem_wen   <= 1'b0;
            own       <= CORE_BIU_OWN_IFU;
            state     <= CORE_BIU_ARB_REQ;
          end
        end
        CORE_BIU_ARB_REQ: begin
          if (mem_req_ready) state <= CORE_BIU_ARB_RSP;
          if (ifu_flush_hit) drop <= 1'b1;
        end
        CORE_BIU_ARB_RSP: begin
          if (mem_rsp_valid) begin
            state <= CORE_BIU_ARB_IDLE;
            drop  <= 1'b0;
            if (own == CORE_BIU_OWN_LSU) begin
              lsu_rsp_valid <= 1'b1;
              lsu_rsp_rdata <= mem_rsp_rdata;
            end else if (!drop && !ifu_flush) begin
              ifu_rsp_valid <= 1'b1;
              ifu_rsp_rdata <= mem_rsp_rdata;
            end
          end else if (ifu_flush_hit) begin
            drop <= 1'b1;
          end
        end
        default: state <= CORE_BIU_ARB_IDLE;
      endcase
    end
  end

`ifdef CORE_BIU_ARB_RR_EN
  logic rr_favor_ifu;

  // After a grant, the next tie goes to the requester that just lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_favor_ifu <= 1'b0;
    end else if (lsu_hs) begin
      rr_favor_ifu <= 1'b1;
    end else if (ifu_hs) begin
      rr_favor_ifu <= 1'b0;
    end
  end
`endif

  // Memory must only answer an accepted request.
  a_stray_rsp: assert property (@(posedge clk) disable iff (rst)
    mem_rsp_valid |-> (state == CORE_BIU_ARB_RSP))
    else $warning("core_biu_arbiter: memory response outside RSP state ignored");

endmodule

// File: tb/tb_core_biu_arbiter.sv
// Scoreboard bench for core_biu_arbiter with a behavioural memory of
// programmable ready delay and response latency.
module tb_core_biu_arbiter;

  localparam int XLEN    = 32;
  localparam int WMASK_W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               ifu_req_valid, ifu_req_ready, ifu_flush;
  logic [XLEN-1:0]    ifu_req_addr;
  logic               ifu_rsp_valid;
  logic [XLEN-1:0]    ifu_rsp_rdata;
  logic               lsu_req_valid, lsu_req_ready, lsu_req_wen;
  logic [XLEN-1:0]    lsu_req_addr, lsu_req_wdata;
  logic [WMASK_W-1:0] lsu_req_wmask;
  logic               lsu_rsp_valid;
  logic [XLEN-1:0]    lsu_rsp_rdata;
  logic               mem_req_valid, mem_req_ready, mem_wen;
  logic [XLEN-1:0]    mem_addr, mem_wdata;
  logic [WMASK_W-1:0] mem_wmask;
  logic               mem_rsp_valid;
  logic [XLEN-1:0]    mem_rsp_rdata;

  always #5 clk = ~clk;

  core_biu_arbiter #(.XLEN(XLEN), .WMASK_W(WMASK_W)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_req_addr(ifu_req_addr), .ifu_flush(ifu_flush),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_rdata(ifu_rsp_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata),
    .lsu_req_wmask(lsu_req_wmask), .lsu_req_wen(lsu_req_wen),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_wen(mem_wen), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
  );

  typedef struct {
    logic        is_lsu;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
  } sb_t;

  sb_t sb_q[$];
  int  hs_cyc_q[$];
  bit  gnt_q[$];
  int  mem_rsp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_dly = 0, mem_lat = 1, stray_cnt = 0, stray_done = 0, rst_epoch = 0;
  int rsp_cnt = 0, ifu_rsp_cnt = 0;
  int acc_cyc = -1, rsp_cyc = -1, mreq_rise_cyc = -1;
  logic mreq_d = 1'b0;
  bit  watch_req = 0;
  int  watch_cnt = 0;
  logic [31:0] watch_addr = '0;
  int  lsu_left = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    return (a == 32'h8000_0010) ? 32'hDEAD_BEEF : {a[15:0] ^ 16'h5A5A, a[31:16]};
  endfunction

  // Behavioural memory: drives its inputs 3 time units after each rising edge.
  int          mem_ep;
  logic [31:0] mem_rd;
  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    forever begin
      @(posedge clk); #3;
      if (stray_cnt != stray_done) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #3;
        mem_rsp_valid = 1'b0;
        stray_done++;
      end else if (mem_req_valid === 1'b1) begin
        mem_ep = rst_epoch;
        for (int i = 0; i < ready_dly; i++) begin @(posedge clk); #3; end
        mem_req_ready = 1'b1;
        mem_rd = model_rdata(mem_addr);
        @(posedge clk); #3;
        mem_req_ready = 1'b0;
        for (int i = 1; i < mem_lat; i++) begin @(posedge clk); #3; end
        if (mem_ep == rst_epoch) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = mem_rd;
          @(posedge clk); #3;
          mem_rsp_valid = 1'b0;
        end
      end
    end
  end

  // One clock cycle: sample at the falling edge, update drivers after the rising edge.
  task automatic tick();
    bit  ifu_hs = 0;
    bit  lsu_hs = 0;
    sb_t e;
    @(negedge clk);
    if (!rst) begin
      if (ifu_req_valid && lsu_req_valid)
        check("one_ready", {ifu_req_ready, lsu_req_ready} == 2'b11, 0);
      if (ifu_req_valid && ifu_req_ready) begin
        ifu_hs = 1;
        sb_q.push_back('{1'b0, 1'b0, ifu_req_addr, 32'h0, 4'h0, model_rdata(ifu_req_addr)});
        gnt_q.push_back(1'b0);
        hs_cyc_q.push_back(cyc);
      end
      if (lsu_req_valid && lsu_req_ready) begin
        lsu_hs = 1;
        sb_q.push_back('{1'b1, lsu_req_wen, lsu_req_addr, lsu_req_wdata, lsu_req_wmask,
                         model_rdata(lsu_req_addr)});
        gnt_q.push_back(1'b1);
        hs_cyc_q.push_back(cyc);
      end
      if (mem_req_valid && !mreq_d) mreq_rise_cyc = cyc;
      if (watch_req && mem_req_valid) begin
        watch_cnt++;
        check("hold_addr", mem_addr, watch_addr);
        check("hold_wen", mem_wen, 0);
        check("hold_wmask", mem_wmask, 0);
        check("hold_lsu_ready", lsu_req_ready, 0);
        if (mem_req_ready) watch_req = 0;
      end
      if (mem_req_valid && mem_req_ready) begin
        acc_cyc = cyc;
        if (sb_q.size() == 0) check("acc_unexpected", 1, 0);
        else begin
          e = sb_q[0];
          check("mem_addr", mem_addr, e.addr);
          check("mem_wen", mem_wen, e.wen);
          check("mem_wmask", mem_wmask, e.wmask);
          if (e.wen) check("mem_wdata", mem_wdata, e.wdata);
        end
      end
      if (mem_rsp_valid) mem_rsp_q.push_back(cyc);
      if (ifu_rsp_valid || lsu_rsp_valid) begin
        rsp_cyc = cyc;
        rsp_cnt++;
        if (ifu_rsp_valid) ifu_rsp_cnt++;
        if (sb_q.size() == 0) check("rsp_unexpected", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
        else begin
          e = sb_q.pop_front();
          check("rsp_owner", {ifu_rsp_valid, lsu_rsp_valid}, e.is_lsu ? 2'b01 : 2'b10);
          if (!e.wen) check("rsp_rdata", e.is_lsu ? lsu_rsp_rdata : ifu_rsp_rdata, e.rdata);
        end
      end
    end
    mreq_d = mem_req_valid;
    @(posedge clk); #1;
    cyc++;
    if (ifu_hs) ifu_req_valid = 1'b0;
    if (lsu_hs) begin
      if (lsu_left > 0) begin
        lsu_left--;
        lsu_req_addr = lsu_req_addr + 32'd4;
      end else lsu_req_valid = 1'b0;
    end
  endtask

  task automatic run_idle(input string tag, input int budget);
    int n = 0;
    while ((ifu_req_valid || lsu_req_valid || sb_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (ifu_req_valid || lsu_req_valid || sb_q.size() != 0) check({tag, "_timeout"}, 1, 0);
    tick();
    tick();
  endtask

  task automatic wait_acc(input string tag);
    int a0 = acc_cyc;
    int n = 0;
    while (acc_cyc == a0 && n < 30) begin tick(); n++; end
    if (acc_cyc == a0) check({tag, "_acc_timeout"}, 1, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rst_epoch++;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    sb_q.delete();
    tick();
  endtask

  task automatic drive_lsu(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] m);
    lsu_req_valid = 1'b1;
    lsu_req_addr  = a;
    lsu_req_wen   = w;
    lsu_req_wdata = d;
    lsu_req_wmask = m;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit exp_ord[3];
    int r0;
    int k;
    rst = 1'b1;
    ifu_req_valid = 0; ifu_req_addr = '0; ifu_flush = 0;
    lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_wdata = '0; lsu_req_wmask = '0; lsu_req_wen = 0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    @(negedge clk);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_ifu_rsp_valid", ifu_rsp_valid, 0);
    check("rst_lsu_rsp_valid", lsu_rsp_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_wmask", mem_wmask, 0);
    check("rst_mem_wen", mem_wen, 0);
    check("rst_ifu_rdata", ifu_rsp_rdata, 0);
    check("rst_lsu_rdata", lsu_rsp_rdata, 0);
    check("rst_ready", {ifu_req_ready, lsu_req_ready}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // LSU load, memory latency 3
    mem_lat = 3; ready_dly = 0;
    hs_cyc_q.delete();
    drive_lsu(32'h8000_0010, 1'b0, 32'h0, 4'h0);
    run_idle("lsu_load", 50);
    check("lsu_hs_to_mem_valid", mreq_rise_cyc - hs_cyc_q[0], 1);
    check("lsu_acc_to_rsp", rsp_cyc - acc_cyc, 4);
    check("lsu_load_ifu_rsp", ifu_rsp_cnt, 0);

    // Contention from reset: LSU issues two back-to-back stores, IFU one fetch
    do_reset();
    gnt_q.delete();
    mem_lat = 2;
    lsu_left = 1;
    drive_lsu(32'h8000_0100, 1'b1, 32'h1234_5678, 4'hF);
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0000;
`ifdef CORE_BIU_ARB_RR_EN
    exp_ord = '{1'b1, 1'b0, 1'b1};
`else
    exp_ord = '{1'b1, 1'b1, 1'b0};
`endif
    run_idle("contend", 100);
    check("contend_count", gnt_q.size(), 3);
    for (int i = 0; i < 3; i++) check($sformatf("contend_gnt%0d", i), gnt_q[i], exp_ord[i]);

    // Fetch held in REQ for 5 cycles while the LSU waits
    ready_dly = 5;
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0000;
    watch_addr    = 32'h8000_0000;
    tick();
    watch_cnt = 0;
    watch_req = 1;
    drive_lsu(32'h8000_0020, 1'b0, 32'h0, 4'h0);
    run_idle("hold", 100);
    check("hold_cycles", watch_cnt, 6);
    ready_dly = 0;

    // Flush blocks IFU ready in IDLE
    ifu_flush = 1'b1;
    ifu_req_valid = 1'b1;
    ifu_req_addr = 32'h8000_0040;
    @(negedge clk);
    check("flush_ready_low", ifu_req_ready, 0);
    @(posedge clk); #1;
    cyc++;
    ifu_flush = 1'b0;

    // Flush during RSP: response swallowed, next fetch accepted right after
    mem_lat = 4;
    wait_acc("flush");
    ifu_flush = 1'b1;
    tick();
    ifu_flush = 1'b0;
    void'(sb_q.pop_front());
    r0 = ifu_rsp_cnt;
    mem_rsp_q.delete();
    hs_cyc_q.delete();
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0080;
    run_idle("flush_next", 60);
    check("flush_rsp_count", ifu_rsp_cnt - r0, 1);
    check("flush_next_hs", hs_cyc_q[0] - mem_rsp_q[0], 1);

    // Flush in the same cycle as the memory response
    mem_lat = 2;
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0044;
    wait_acc("flush_same");
    tick();
    ifu_flush = 1'b1;
    k = cyc;
    mem_rsp_q.delete();
    tick();
    ifu_flush = 1'b0;
    void'(sb_q.pop_front());
    r0 = ifu_rsp_cnt;
    repeat (3) tick();
    check("flush_same_rsp_cyc", mem_rsp_q[0], k);
    check("flush_same_no_rsp", ifu_rsp_cnt - r0, 0);

    // Back-to-back LSU loads at latency 1
    mem_lat = 1;
    hs_cyc_q.delete();
    lsu_left = 1;
    drive_lsu(32'h8000_0200, 1'b0, 32'h0, 4'h0);
    run_idle("b2b", 40);
    check("b2b_count", hs_cyc_q.size(), 2);
    check("b2b_spacing", hs_cyc_q[1] - hs_cyc_q[0], 3);
    check("b2b_acc_to_rsp", rsp_cyc - acc_cyc, 2);

    // Mixed traffic with random memory timing
    for (int i = 0; i < 10; i++) begin
      ready_dly = $urandom_range(0, 2);
      mem_lat   = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 0) begin
        ifu_req_valid = 1'b1;
        ifu_req_addr  = {16'h8000, 16'($urandom_range(0, 16'h3FFF) << 2)};
      end else begin
        drive_lsu({16'h8000, 16'($urandom_range(0, 16'h3FFF) << 2)}, 1'($urandom_range(0, 1)),
                  $urandom, 4'($urandom_range(1, 15)));
      end
      run_idle("rand", 40);
    end
    ready_dly = 0;

    // Reset while waiting for a response
    mem_lat = 6;
    drive_lsu(32'h8000_0300, 1'b0, 32'h0, 4'h0);
    wait_acc("rst_rsp");
    tick();
    rst = 1'b1;
    rst_epoch++;
    tick();
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("rstrsp_mem_req_valid", mem_req_valid, 0);
    check("rstrsp_rsp_valids", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
    check("rstrsp_mem_addr", mem_addr, 0);
    @(posedge clk); #1;
    cyc++;
    r0 = ifu_rsp_cnt;
    mem_lat = 2;
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0400;
    run_idle("rstrsp_next", 60);
    check("rstrsp_next_rsp", ifu_rsp_cnt - r0, 1);

    // Stray memory response while idle
    r0 = rsp_cnt;
    stray_cnt++;
    repeat (4) tick();
    check("stray_no_rsp", rsp_cnt - r0, 0);
    check("stray_idle", mem_req_valid, 0);
    drive_lsu(32'h8000_0010, 1'b0, 32'h0, 4'h0);
    run_idle("after_stray", 40);
    check("after_stray_rsp", rsp_cnt - r0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
